// File: rtl/store_write_buffer.sv
// -----------------------------------------------------------------------------
// store_write_buffer
//
// Posted-write buffer between the core's data-memory port and a slower data
// memory. Every accepted store is held in a small in-order circular FIFO and
// retired to memory over a valid/ready handshake. Loads can be checked against
// the pending stores; the youngest matching store's data is forwarded. When the
// FIFO is full the core is stalled.
//
// Parameters:
//   DEPTH  number of buffered stores (power of two, 2..16)
//   AW     address width
//   DW     data width
//
// Ports:
//   clk        in   single clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset
//   MemWrite   in   core store request this cycle
//   DataAdr    in   store byte address (word-aligned)
//   WriteData  in   store data
//   Stall      out  buffer full; a store presented now is not accepted
//   LdAdr      in   load address checked for forwarding
//   LdHit      out  a pending entry matches LdAdr (word granularity)
//   LdData     out  data of the youngest matching entry, 0 when no hit
//   mem_we     out  head entry valid toward memory
//   mem_adr    out  head entry address
//   mem_wdata  out  head entry data
//   mem_ready  in   memory accepts the head entry this cycle
//   Empty      out  no pending entries
// -----------------------------------------------------------------------------
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [AW-1:0] DataAdr,
    input  logic [DW-1:0] WriteData,
    output logic          Stall,
    input  logic [AW-1:0] LdAdr,
    output logic          LdHit,
    output logic [DW-1:0] LdData,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    output logic          Empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [AW-1:0] adr_mem  [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic          enq;
    logic          deq;
    logic [PW-1:0] fwd_idx;

    // Status and memory-side outputs depend on registered state only.
    assign Stall     = (count == FULL_COUNT);
    assign Empty     = (count == '0);
    assign mem_we    = ~Empty;
    assign mem_adr   = adr_mem[head];
    assign mem_wdata = data_mem[head];

    // No full-bypass: a dequeue in the same cycle does not open a slot for an
    // enqueue while full. mem_ready is ignored when empty because mem_we=0.
    assign enq = MemWrite & ~Stall;
    assign deq = mem_we & mem_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the entry array is deliberately not reset; validity is tracked by
    // head/count, so stale contents are never observed and the array can map
    // onto plain storage without a reset network.
    always_ff @(posedge clk) begin
        if (enq) begin
            adr_mem[tail]  <= DataAdr;
            data_mem[tail] <= WriteData;
        end
    end

    // Forwarding: walk valid entries from oldest (head) to youngest, letting a
    // later match override an earlier one so the youngest store wins. Only the
    // registered array takes part, so a store enqueued this cycle is invisible
    // and one dequeued this cycle is still visible.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        LdHit   = 1'b0;
        LdData  = '0;
        fwd_idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PW'(i);
            if (((PW + 1)'(i) < count) &&
                (adr_mem[fwd_idx][AW-1:2] == LdAdr[AW-1:2])) begin
                LdHit  = 1'b1;
                LdData = data_mem[fwd_idx];
            end
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_write_buffer
//
// Self-checking bench for store_write_buffer. A queue-based reference model
// tracks pending stores; directed scenarios follow the buffer's intended use
// and a randomized phase compares every output against the model each cycle.
// -----------------------------------------------------------------------------
module tb_store_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemWrite;
    logic [AW-1:0] DataAdr;
    logic [DW-1:0] WriteData;
    logic          Stall;
    logic [AW-1:0] LdAdr;
    logic          LdHit;
    logic [DW-1:0] LdData;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          Empty;

    int checks = 0;
    int errors = 0;

    entry_t model_q[$];

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .Stall     (Stall),
        .LdAdr     (LdAdr),
        .LdHit     (LdHit),
        .LdData    (LdData),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .Empty     (Empty)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached (actual still running, required finished)");
        $fatal(1, "watchdog");
    end

    // Reference model: a FIFO of pending stores updated from the inputs seen
    // at each rising edge.
    task automatic cycle();
        entry_t e;
        bit     do_enq;
        bit     do_deq;
        @(posedge clk);
        if (reset) begin
            model_q.delete();
        end else begin
            do_deq = (model_q.size() > 0) && mem_ready;
            do_enq = MemWrite && (model_q.size() < DEPTH);
            if (do_deq) void'(model_q.pop_front());
            if (do_enq) begin
                e.adr  = DataAdr;
                e.data = WriteData;
                model_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    // Youngest pending store with the same word address.
    function automatic void model_fwd(input logic [AW-1:0] adr,
                                      output logic hit, output logic [DW-1:0] data);
        hit  = 1'b0;
        data = '0;
        for (int k = model_q.size() - 1; k >= 0; k--) begin
            if (model_q[k].adr[AW-1:2] == adr[AW-1:2]) begin
                hit  = 1'b1;
                data = model_q[k].data;
                break;
            end
        end
    endfunction

    task automatic idle_inputs();
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        mem_ready = 1'b0;
        LdAdr     = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        checks++;
        if ({Stall, Empty, mem_we, LdHit} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_flags: Stall/Empty/mem_we/LdHit=%b required 0100", {Stall, Empty, mem_we, LdHit});
        end
        checks++;
        if (LdData !== '0) begin
            errors++;
            $display("FAIL reset_lddata: got %h required 0", LdData);
        end
    endtask

    task automatic test_single_store();
        MemWrite = 1'b1; DataAdr = 32'h40; WriteData = 32'hDEADBEEF; mem_ready = 1'b1;
        cycle();
        MemWrite = 1'b0;
        #1;
        checks++;
        if ({mem_we, mem_adr, mem_wdata} !== {1'b1, 32'h40, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_head: we=%b adr=%h data=%h required 1/40/deadbeef", mem_we, mem_adr, mem_wdata);
        end
        cycle();
        #1;
        checks++;
        if ({Empty, mem_we} !== 2'b10) begin
            errors++;
            $display("FAIL single_drained: Empty/mem_we=%b required 10", {Empty, mem_we});
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_fill();
        mem_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            #1;
            if (Stall !== 1'b0) begin
                errors++;
                $display("FAIL fill_early_stall: store %0d got Stall=%b required 0", i, Stall);
            end
            MemWrite = 1'b1; DataAdr = 32'(4 * i); WriteData = 32'(100 + i);
            cycle();
        end
        #1;
        checks++;
        if (Stall !== 1'b1) begin
            errors++;
            $display("FAIL fill_stall: got Stall=%b required 1", Stall);
        end
        // Fifth store must be refused.
        DataAdr = 32'h10; WriteData = 32'h999;
        cycle();
        MemWrite  = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if ({mem_we, mem_adr, mem_wdata} !== {1'b1, 32'(4 * i), 32'(100 + i)}) begin
                errors++;
                $display("FAIL fill_order: slot %0d we=%b adr=%h data=%h required 1/%h/%h",
                         i, mem_we, mem_adr, mem_wdata, 32'(4 * i), 32'(100 + i));
            end
            cycle();
            if (i == 0) begin
                #1;
                checks++;
                if (Stall !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_unstall: got Stall=%b required 0", Stall);
                end
            end
        end
        #1;
        checks++;
        if (Empty !== 1'b1) begin
            errors++;
            $display("FAIL fill_fifth_refused: got Empty=%b required 1", Empty);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_forwarding();
        logic [AW-1:0] adrs [3] = '{32'h20, 32'h24, 32'h20};
        logic [DW-1:0] dats [3] = '{32'h11, 32'h22, 32'h33};
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MemWrite = 1'b1; DataAdr = adrs[i]; WriteData = dats[i];
            cycle();
        end
        MemWrite = 1'b0;
        LdAdr = 32'h22;
        #1;
        checks++;
        if ({LdHit, LdData} !== {1'b1, 32'h33}) begin
            errors++;
            $display("FAIL fwd_youngest: hit=%b data=%h required 1/33", LdHit, LdData);
        end
        LdAdr = 32'h28;
        #1;
        checks++;
        if ({LdHit, LdData} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL fwd_miss: hit=%b data=%h required 0/0", LdHit, LdData);
        end
        LdAdr = 32'h24;
        #1;
        checks++;
        if ({LdHit, LdData} !== {1'b1, 32'h22}) begin
            errors++;
            $display("FAIL fwd_single: hit=%b data=%h required 1/22", LdHit, LdData);
        end
        // Store being enqueued this cycle is not yet visible.
        MemWrite = 1'b1; DataAdr = 32'h28; WriteData = 32'h44; LdAdr = 32'h28;
        #1;
        checks++;
        if (LdHit !== 1'b0) begin
            errors++;
            $display("FAIL fwd_same_cycle_enq: hit=%b required 0", LdHit);
        end
        cycle();
        MemWrite = 1'b0;
        #1;
        checks++;
        if ({LdHit, LdData} !== {1'b1, 32'h44}) begin
            errors++;
            $display("FAIL fwd_after_enq: hit=%b data=%h required 1/44", LdHit, LdData);
        end
        // Head entry being dequeued this cycle is still visible.
        LdAdr = 32'h20; mem_ready = 1'b1;
        #1;
        checks++;
        if ({LdHit, LdData} !== {1'b1, 32'h33}) begin
            errors++;
            $display("FAIL fwd_during_deq: hit=%b data=%h required 1/33", LdHit, LdData);
        end
        repeat (4) cycle();
        mem_ready = 1'b0;
        LdAdr = '0;
    endtask

    task automatic test_streaming_wrap();
        mem_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            MemWrite = 1'b1; DataAdr = 32'(32'h100 + 4 * i); WriteData = 32'(i);
            cycle();
            #1;
            checks++;
            if ({Stall, mem_we, mem_wdata} !== {1'b0, 1'b1, 32'(i)}) begin
                errors++;
                $display("FAIL stream_%0d: Stall=%b we=%b data=%h required 0/1/%h",
                         i, Stall, mem_we, mem_wdata, 32'(i));
            end
        end
        MemWrite = 1'b0;
        cycle();
        #1;
        checks++;
        if (Empty !== 1'b1) begin
            errors++;
            $display("FAIL stream_drained: got Empty=%b required 1", Empty);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_backpressure_hold();
        mem_ready = 1'b0;
        MemWrite = 1'b1; DataAdr = 32'h50; WriteData = 32'hAA;
        cycle();
        MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({mem_we, mem_adr, mem_wdata} !== {1'b1, 32'h50, 32'hAA}) begin
                errors++;
                $display("FAIL hold_%0d: we=%b adr=%h data=%h required 1/50/aa", i, mem_we, mem_adr, mem_wdata);
            end
            cycle();
        end
        mem_ready = 1'b1;
        cycle();
        #1;
        checks++;
        if (Empty !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got Empty=%b required 1", Empty);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MemWrite = 1'b1; DataAdr = 32'(32'h200 + 4 * i); WriteData = 32'(i + 7);
            cycle();
        end
        MemWrite = 1'b0;
        mem_ready = 1'b1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({Empty, mem_we, Stall} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset: Empty/mem_we/Stall=%b required 100", {Empty, mem_we, Stall});
        end
        MemWrite = 1'b1; DataAdr = 32'h60; WriteData = 32'h5; mem_ready = 1'b1;
        cycle();
        MemWrite = 1'b0;
        #1;
        checks++;
        if ({mem_we, mem_adr, mem_wdata} !== {1'b1, 32'h60, 32'h5}) begin
            errors++;
            $display("FAIL post_reset_store: we=%b adr=%h data=%h required 1/60/5", mem_we, mem_adr, mem_wdata);
        end
        cycle();
        #1;
        checks++;
        if (Empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_drain: got Empty=%b required 1", Empty);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_random();
        logic          exp_hit;
        logic [DW-1:0] exp_data;
        int            n;
        for (int c = 0; c < 2000; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            MemWrite  = ($urandom_range(0, 99) < 60);
            DataAdr   = {28'h0, 2'($urandom_range(0, 3)), 2'b00} + 32'h300;
            WriteData = $urandom;
            mem_ready = ($urandom_range(0, 99) < 45);
            LdAdr     = {28'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))} + 32'h300;
            #1;
            n = model_q.size();
            model_fwd(LdAdr, exp_hit, exp_data);
            checks++;
            if ({Stall, Empty, mem_we} !== {n == DEPTH, n == 0, n != 0}) begin
                errors++;
                $display("FAIL rand_status cycle %0d: Stall/Empty/mem_we=%b required %b",
                         c, {Stall, Empty, mem_we}, {n == DEPTH, n == 0, n != 0});
            end
            if (n != 0) begin
                checks++;
                if ({mem_adr, mem_wdata} !== {model_q[0].adr, model_q[0].data}) begin
                    errors++;
                    $display("FAIL rand_head cycle %0d: adr=%h data=%h required %h/%h",
                             c, mem_adr, mem_wdata, model_q[0].adr, model_q[0].data);
                end
            end
            checks++;
            if ({LdHit, LdData} !== {exp_hit, exp_data}) begin
                errors++;
                $display("FAIL rand_fwd cycle %0d: ld %h hit=%b data=%h required %b/%h",
                         c, LdAdr, LdHit, LdData, exp_hit, exp_data);
            end
            cycle();
        end
        reset = 1'b0;
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_store();
        test_fill();
        test_forwarding();
        test_streaming_wrap();
        test_backpressure_hold();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Posted-write buffer between the pipelined core's data-memory port and a slower data memory. Captures every store the core issues (MemWrite, DataAdr, WriteData), holds it in a small in-order FIFO, and retires entries to memory through a valid/ready handshake. A load address can be checked against pending stores; the youngest matching store data is forwarded. When full, the buffer stalls the core.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; a power of two, 2..16.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- MemWrite  in  1  core store request this cycle.
- DataAdr  in  AW  store address, byte address, word-aligned.
- WriteData  in  DW  store data.
- Stall  out  1  buffer full; a store presented while Stall=1 is not accepted.
- LdAdr  in  AW  address of the load being checked for forwarding.
- LdHit  out  1  a pending entry matches LdAdr.
- LdData  out  DW  data of the youngest matching entry; 0 when LdHit=0.
- mem_we  out  1  head entry valid toward memory.
- mem_adr  out  AW  head entry address.
- mem_wdata  out  DW  head entry data.
- mem_ready  in  1  memory accepts the head entry this cycle.
- Empty  out  1  no pending entries.

## Operation
- Storage: circular array of DEPTH entries {adr, data}. Head pointer and tail pointer are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, 0..DEPTH.
- Enqueue: when MemWrite=1 and Stall=0, write {DataAdr, WriteData} at the tail, advance the tail, and increment count.
- Dequeue: when mem_we=1 and mem_ready=1, advance the head and decrement count.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged. This is legal at any count below DEPTH. At count=DEPTH, Stall=1, so enqueue is blocked even if a dequeue happens in the same cycle. There is no full-bypass.
- Stall = (count==DEPTH), combinational from registered count.
- Empty = (count==0). mem_we = ~Empty. mem_adr and mem_wdata are driven from the head entry and stay stable while mem_we=1 and mem_ready=0.
- mem_ready while Empty=1 is ignored; no state changes.
- Forwarding compare:
  - Only valid entries take part, i.e. entries from head up to but not including tail, at most count of them.
  - Addresses compare on bits [AW-1:2].
  - If several entries match, LdData comes from the most recently enqueued one.
  - A store being enqueued in the same cycle is not visible to the compare.
  - An entry being dequeued in the same cycle is still visible.
- Order: memory sees stores strictly in issue order. There is no coalescing and no reordering.

## Timing
- Reset: count=0, head=tail=0, Stall=0, Empty=1, mem_we=0, LdHit=0, LdData=0. Entry array contents are don't-care.
- Reset asserted mid-operation discards all pending stores. mem_we drops on the cycle after the reset edge.
- Latency: a store accepted at edge N appears on mem_we/mem_adr/mem_wdata after edge N, when the buffer was empty. Earliest memory acceptance is edge N+1.
- Throughput: one store per cycle in and out while mem_ready stays high. With this pattern count stays constant.
- Stall, Empty and mem_* are functions of registered state only. LdHit and LdData are combinational from LdAdr and registered state, with no cycle of latency.
- Wrap-around: after DEPTH enqueues, tail returns to 0 and operation continues. Full vs empty is resolved by count, not by pointer equality.

## Test plan
- Reset then a single store, MemWrite=1, DataAdr=0x40, WriteData=0xDEADBEEF, mem_ready=1 → next cycle mem_we=1, mem_adr=0x40, mem_wdata=0xDEADBEEF; one cycle later Empty=1.
- Fill: mem_ready=0, four stores to 0x0, 0x4, 0x8, 0xC → Stall=1 after the 4th edge. A 5th store (0x10) is not accepted. Raise mem_ready → memory sees 0x0, 0x4, 0x8, 0xC in order, and Stall clears after the first drain.
- Forwarding: with mem_ready=0, stores 0x20←0x11, 0x24←0x22, 0x20←0x33; LdAdr=0x22 → LdHit=1, LdData=0x33. LdAdr=0x28 → LdHit=0, LdData=0.
- Streaming wrap: mem_ready=1, 10 back-to-back stores with data 1..10 → count never exceeds 1, Stall never set, and the memory side sees 1..10 in order, with pointers wrapping twice.
- Backpressure hold: entry 0x50←0xAA at head, mem_ready=0 for 5 cycles → mem_adr and mem_wdata stay constant. One cycle with mem_ready=1 → Empty=1 next cycle.
- Reset mid-drain: 3 stores pending, assert reset for one cycle → Empty=1, mem_we=0, Stall=0 next cycle. Subsequent store 0x60←0x5 drains normally.
